// File: rtl/cnn_argmax_head.sv
// -----------------------------------------------------------------------------
// cnn_argmax_head
//
// Classification head behind the CNN core. It takes NUM_CLASSES signed scores
// as a valid-qualified stream and keeps the running maximum. On the last
// accepted score it publishes the winning index and score, and it holds them
// under the startFlag/done level handshake.
//
// Optional feature macro: ARGMAX_TOPTWO_EN
//   defined   : also tracks the runner-up and publishes second_idx and margin
//   undefined : second_idx and margin are tied to 0 and no runner-up logic is
//               built
//
// Parameters
//   NUM_CLASSES  scores per inference (>= 2)
//   DATA_W       score width, two's complement
//   IDX_W        class index width, 2**IDX_W >= NUM_CLASSES
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   startFlag    level request, high = run / hold an inference
//   in_valid     in_data carries a score this cycle
//   in_data      signed class score, class order = arrival order
//   in_ready     high while collecting (decoded from the state register)
//   done         result valid, held until startFlag drops
//   class_idx    index of the maximum score
//   class_score  maximum score
//   second_idx   runner-up index (0 unless ARGMAX_TOPTWO_EN)
//   margin       class_score - runner-up score at DATA_W+1 bits (0 unless
//                ARGMAX_TOPTWO_EN)
//
// State       | meaning
// ------------+---------------------------------------------------------
// ST_IDLE     | waiting for startFlag, stream ignored
// ST_COLLECT  | accepting scores, abort to idle if startFlag drops
// ST_DONE     | result published, wait for startFlag to drop
// -----------------------------------------------------------------------------
module cnn_argmax_head #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 16,
  parameter int IDX_W       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     startFlag,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     done,
  output logic        [IDX_W-1:0]  class_idx,
  output logic signed [DATA_W-1:0] class_score,
  output logic        [IDX_W-1:0]  second_idx,
  output logic signed [DATA_W:0]   margin
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic        [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t                    state_q, state_d;
  logic        [IDX_W-1:0]   cnt_q, cnt_d;
  logic signed [DATA_W-1:0]  max_q, max_d;
  logic        [IDX_W-1:0]   max_idx_q, max_idx_d;
  logic signed [DATA_W-1:0]  out_score_q, out_score_d;
  logic        [IDX_W-1:0]   out_idx_q, out_idx_d;

  logic                      accept;
  logic                      last_sample;
  logic                      init_run;
  logic                      step_run;
  logic                      publish;
  logic                      new_max;
  logic signed [DATA_W-1:0]  run_max_nx;
  logic        [IDX_W-1:0]   run_idx_nx;

  assign accept      = (state_q == ST_COLLECT) && in_valid;
  assign last_sample = (cnt_q == LAST_IDX);
  assign init_run    = (state_q == ST_IDLE) && startFlag;
  // The final sample completes even if startFlag drops on the same edge.
  assign publish     = accept && last_sample;
  assign step_run    = accept && (last_sample || startFlag);

  // Sample 0 always loads so an all-most-negative stream still reports idx 0.
  assign new_max     = (cnt_q == '0) || (in_data > max_q);
  assign run_max_nx  = new_max ? in_data : max_q;
  assign run_idx_nx  = new_max ? cnt_q   : max_idx_q;

  assign in_ready    = (state_q == ST_COLLECT);
  assign done        = (state_q == ST_DONE);
  assign class_idx   = out_idx_q;
  assign class_score = out_score_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (startFlag) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (publish)         state_d = ST_DONE;
        else if (!startFlag) state_d = ST_IDLE;
      end
      ST_DONE: begin
        if (!startFlag) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    max_d       = max_q;
    max_idx_d   = max_idx_q;
    out_score_d = out_score_q;
    out_idx_d   = out_idx_q;
    if (init_run) begin
      cnt_d     = '0;
      max_d     = MOST_NEG;
      max_idx_d = '0;
    end else if (step_run) begin
      cnt_d     = cnt_q + IDX_W'(1);
      max_d     = run_max_nx;
      max_idx_d = run_idx_nx;
    end
    if (publish) begin
      out_score_d = run_max_nx;
      out_idx_d   = run_idx_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      max_q       <= '0;
      max_idx_q   <= '0;
      out_score_q <= '0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      max_q       <= max_d;
      max_idx_q   <= max_idx_d;
      out_score_q <= out_score_d;
      out_idx_q   <= out_idx_d;
    end
  end

`ifdef ARGMAX_TOPTWO_EN
  logic signed [DATA_W-1:0]  sec_q, sec_d;
  logic        [IDX_W-1:0]   sec_idx_q, sec_idx_d;
  logic        [IDX_W-1:0]   out_sec_idx_q, out_sec_idx_d;
  logic signed [DATA_W:0]    out_margin_q, out_margin_d;
  logic signed [DATA_W-1:0]  run_sec_nx;
  logic        [IDX_W-1:0]   run_sec_idx_nx;
  logic                      sec_upd;

  // A score equal to the current max is neither a new max nor a runner-up,
  // so repeated maxima leave the runner-up at the next distinct value.
  assign sec_upd = (in_data > sec_q) && (in_data != max_q);

  always_comb begin
    run_sec_nx     = sec_q;
    run_sec_idx_nx = sec_idx_q;
    if (new_max) begin
      run_sec_nx     = max_q;
      run_sec_idx_nx = max_idx_q;
    end else if (sec_upd) begin
      run_sec_nx     = in_data;
      run_sec_idx_nx = cnt_q;
    end
  end

  always_comb begin
    sec_d         = sec_q;
    sec_idx_d     = sec_idx_q;
    out_sec_idx_d = out_sec_idx_q;
    out_margin_d  = out_margin_q;
    if (init_run) begin
      sec_d     = MOST_NEG;
      sec_idx_d = '0;
    end else if (step_run) begin
      sec_d     = run_sec_nx;
      sec_idx_d = run_sec_idx_nx;
    end
    if (publish) begin
      out_sec_idx_d = run_sec_idx_nx;
      // One extra bit keeps max - min representable without overflow.
      out_margin_d  = {run_max_nx[DATA_W-1], run_max_nx}
                    - {run_sec_nx[DATA_W-1], run_sec_nx};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec_q         <= '0;
      sec_idx_q     <= '0;
      out_sec_idx_q <= '0;
      out_margin_q  <= '0;
    end else begin
      sec_q         <= sec_d;
      sec_idx_q     <= sec_idx_d;
      out_sec_idx_q <= out_sec_idx_d;
      out_margin_q  <= out_margin_d;
    end
  end

  assign second_idx = out_sec_idx_q;
  assign margin     = out_margin_q;
`else
  assign second_idx = '0;
  assign margin     = '0;
`endif

endmodule

// File: tb/tb_cnn_argmax_head.sv
module tb_cnn_argmax_head;

  logic               clk;
  logic               rst;
  logic               startFlag;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               in_ready;
  logic               done;
  logic        [3:0]  class_idx;
  logic signed [15:0] class_score;
  logic        [3:0]  second_idx;
  logic signed [16:0] margin;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [15:0] sc [10];
  int ready_cycles;
  int early_done;

  cnn_argmax_head #(.NUM_CLASSES(10), .DATA_W(16), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .startFlag(startFlag), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .done(done),
    .class_idx(class_idx), .class_score(class_score),
    .second_idx(second_idx), .margin(margin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Raises startFlag, waits (bounded) for in_ready, then streams n scores from
  // sc with `gap` idle cycles before each. drop_last lowers startFlag together
  // with the final sample. Ends 1 time unit after the last accepting edge.
  task automatic feed(input int n, input int gap, input bit drop_last);
    startFlag    = 1'b1;
    in_valid     = 1'b0;
    ready_cycles = 0;
    early_done   = 0;
    for (int w = 0; w < 20; w++) begin
      @(posedge clk); #1;
      ready_cycles++;
      if (in_ready) break;
    end
    if (!in_ready) ready_cycles = 99;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
        if (done) early_done++;
      end
      in_valid = 1'b1;
      in_data  = sc[i];
      if (drop_last && i == n - 1) startFlag = 1'b0;
      @(posedge clk); #1;
      if (i < 9 && done) early_done++;
    end
    in_valid = 1'b0;
  endtask

  task automatic drop_start();
    startFlag = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; startFlag = 1'b0; in_valid = 1'b0; in_data = '0;
    #12;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", in_ready); end
    n_checks++; if (class_idx !== 4'd0) begin n_fail++; $display("FAIL reset_idx got %0d want 0", class_idx); end
    n_checks++; if (class_score !== 16'sd0) begin n_fail++; $display("FAIL reset_score got %0d want 0", class_score); end
    n_checks++; if (second_idx !== 4'd0) begin n_fail++; $display("FAIL reset_second got %0d want 0", second_idx); end
    n_checks++; if (margin !== 17'sd0) begin n_fail++; $display("FAIL reset_margin got %0d want 0", margin); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    sc = '{16'sd3, -16'sd7, 16'sd12, 16'sd5, 16'sd12, 16'sd0, -16'sd1, 16'sd4, 16'sd9, 16'sd2};
    feed(10, 0, 1'b0);
    n_checks++; if (ready_cycles !== 1) begin n_fail++; $display("FAIL basic_ready_lat got %0d want 1", ready_cycles); end
    n_checks++; if (early_done !== 0) begin n_fail++; $display("FAIL basic_early_done got %0d want 0", early_done); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done got %b want 1", done); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_in_done got %b want 0", in_ready); end
    n_checks++; if (class_idx !== 4'd2) begin n_fail++; $display("FAIL basic_idx got %0d want 2", class_idx); end
    n_checks++; if (class_score !== 16'sd12) begin n_fail++; $display("FAIL basic_score got %0d want 12", class_score); end
`ifdef ARGMAX_TOPTWO_EN
    n_checks++; if (second_idx !== 4'd8) begin n_fail++; $display("FAIL basic_second got %0d want 8", second_idx); end
    n_checks++; if (margin !== 17'sd3) begin n_fail++; $display("FAIL basic_margin got %0d want 3", margin); end
`else
    n_checks++; if (second_idx !== 4'd0) begin n_fail++; $display("FAIL basic_second got %0d want 0", second_idx); end
    n_checks++; if (margin !== 17'sd0) begin n_fail++; $display("FAIL basic_margin got %0d want 0", margin); end
`endif
    drop_start();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_fall got %b want 0", done); end
  endtask

  task automatic test_all_neg();
    for (int i = 0; i < 10; i++) sc[i] = 16'sh8000;
    feed(10, 0, 1'b0);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL neg_done got %b want 1", done); end
    n_checks++; if (class_idx !== 4'd0) begin n_fail++; $display("FAIL neg_idx got %0d want 0", class_idx); end
    n_checks++; if (class_score !== 16'sh8000) begin n_fail++; $display("FAIL neg_score got %0d want -32768", class_score); end
    n_checks++; if (margin !== 17'sd0) begin n_fail++; $display("FAIL neg_margin got %0d want 0", margin); end
    drop_start();
  endtask

  task automatic test_gapped();
    sc = '{16'sd5, -16'sd3, 16'sd20, 16'sd7, -16'sd50, 16'sd99, 16'sd0, 16'sd11, 16'sd42, 16'sd100};
    feed(10, 2, 1'b0);
    n_checks++; if (early_done !== 0) begin n_fail++; $display("FAIL gap_early_done got %0d want 0", early_done); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL gap_done got %b want 1", done); end
    n_checks++; if (class_idx !== 4'd9) begin n_fail++; $display("FAIL gap_idx got %0d want 9", class_idx); end
    n_checks++; if (class_score !== 16'sd100) begin n_fail++; $display("FAIL gap_score got %0d want 100", class_score); end
`ifdef ARGMAX_TOPTWO_EN
    n_checks++; if (second_idx !== 4'd5) begin n_fail++; $display("FAIL gap_second got %0d want 5", second_idx); end
    n_checks++; if (margin !== 17'sd1) begin n_fail++; $display("FAIL gap_margin got %0d want 1", margin); end
`endif
    drop_start();
  endtask

  task automatic test_abort();
    sc = '{16'sd3, -16'sd7, 16'sd12, 16'sd5, 16'sd12, 16'sd0, -16'sd1, 16'sd4, 16'sd9, 16'sd2};
    feed(10, 0, 1'b0);
    drop_start();
    sc = '{16'sd50, 16'sd60, 16'sd70, 16'sd80, 16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1};
    feed(4, 0, 1'b0);
    drop_start();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready got %b want 0", in_ready); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got %b want 0", done); end
    n_checks++; if (class_idx !== 4'd2) begin n_fail++; $display("FAIL abort_idx_kept got %0d want 2", class_idx); end
    n_checks++; if (class_score !== 16'sd12) begin n_fail++; $display("FAIL abort_score_kept got %0d want 12", class_score); end
    sc = '{-16'sd5, -16'sd4, -16'sd3, -16'sd2, -16'sd1, 16'sd0, 16'sd1, 16'sd2, 16'sd3, -16'sd9};
    feed(10, 0, 1'b0);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL abort_rerun_done got %b want 1", done); end
    n_checks++; if (class_idx !== 4'd8) begin n_fail++; $display("FAIL abort_rerun_idx got %0d want 8", class_idx); end
    n_checks++; if (class_score !== 16'sd3) begin n_fail++; $display("FAIL abort_rerun_score got %0d want 3", class_score); end
`ifdef ARGMAX_TOPTWO_EN
    n_checks++; if (second_idx !== 4'd7) begin n_fail++; $display("FAIL abort_rerun_second got %0d want 7", second_idx); end
    n_checks++; if (margin !== 17'sd1) begin n_fail++; $display("FAIL abort_rerun_margin got %0d want 1", margin); end
`endif
    drop_start();
  endtask

  task automatic test_async_reset();
    sc = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd7, 16'sd8, 16'sd9, 16'sd10};
    feed(5, 0, 1'b0);
    #2 rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL arst_ready got %b want 0", in_ready); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL arst_done got %b want 0", done); end
    n_checks++; if (class_idx !== 4'd0) begin n_fail++; $display("FAIL arst_idx got %0d want 0", class_idx); end
    n_checks++; if (class_score !== 16'sd0) begin n_fail++; $display("FAIL arst_score got %0d want 0", class_score); end
    n_checks++; if (margin !== 17'sd0) begin n_fail++; $display("FAIL arst_margin got %0d want 0", margin); end
    #1 rst = 1'b1;
    sc = '{16'sd3, -16'sd7, 16'sd12, 16'sd5, 16'sd12, 16'sd0, -16'sd1, 16'sd4, 16'sd9, 16'sd2};
    feed(10, 0, 1'b0);
    n_checks++; if (ready_cycles !== 1) begin n_fail++; $display("FAIL arst_ready_lat got %0d want 1", ready_cycles); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL arst_run_done got %b want 1", done); end
    n_checks++; if (class_idx !== 4'd2) begin n_fail++; $display("FAIL arst_run_idx got %0d want 2", class_idx); end
    n_checks++; if (class_score !== 16'sd12) begin n_fail++; $display("FAIL arst_run_score got %0d want 12", class_score); end
    drop_start();
  endtask

  task automatic test_hold_done();
    sc[0] = 16'sh7FFF;
    for (int i = 1; i < 10; i++) sc[i] = 16'sh8000;
    feed(10, 0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL hold_done got %b want 1", done); end
    n_checks++; if (class_idx !== 4'd0) begin n_fail++; $display("FAIL hold_idx got %0d want 0", class_idx); end
    n_checks++; if (class_score !== 16'sh7FFF) begin n_fail++; $display("FAIL hold_score got %0d want 32767", class_score); end
`ifdef ARGMAX_TOPTWO_EN
    n_checks++; if (margin !== 17'h0FFFF) begin n_fail++; $display("FAIL hold_margin got %0d want 65535", margin); end
`else
    n_checks++; if (margin !== 17'sd0) begin n_fail++; $display("FAIL hold_margin got %0d want 0", margin); end
`endif
    startFlag = 1'b0;
    #1;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL hold_done_before_edge got %b want 1", done); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL hold_done_fall got %b want 0", done); end
    n_checks++; if (class_score !== 16'sh7FFF) begin n_fail++; $display("FAIL hold_score_retained got %0d want 32767", class_score); end
  endtask

  task automatic test_back_to_back();
    sc = '{-16'sd1, 16'sd4, 16'sd4, 16'sd2, 16'sd0, 16'sd3, 16'sd1, -16'sd8, 16'sd2, 16'sd6};
    feed(10, 0, 1'b1);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done_pulse got %b want 1", done); end
    n_checks++; if (class_idx !== 4'd9) begin n_fail++; $display("FAIL b2b_idx got %0d want 9", class_idx); end
    n_checks++; if (class_score !== 16'sd6) begin n_fail++; $display("FAIL b2b_score got %0d want 6", class_score); end
`ifdef ARGMAX_TOPTWO_EN
    n_checks++; if (second_idx !== 4'd1) begin n_fail++; $display("FAIL b2b_second got %0d want 1", second_idx); end
    n_checks++; if (margin !== 17'sd2) begin n_fail++; $display("FAIL b2b_margin got %0d want 2", margin); end
`endif
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_end got %b want 0", done); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_ready got %b want 0", in_ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_neg();
    test_gapped();
    test_abort();
    test_async_reset();
    test_hold_done();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
